// File: rtl/bsg_arb_rr_packet_lock.sv
// Round-robin arbiter with packet lock. A rotating-priority winner is chosen,
// and the grant is held on that requester until its last flit is accepted.
module bsg_arb_rr_packet_lock #(
    parameter int inputs_p    = 16,
    parameter int lg_inputs_p = $clog2(inputs_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [inputs_p-1:0]    reqs_v_i,
    input  logic [inputs_p-1:0]    reqs_last_i,
    output logic [inputs_p-1:0]    reqs_yumi_o,
    output logic                   v_o,
    output logic [lg_inputs_p-1:0] tag_o,
    output logic                   last_o,
    input  logic                   ready_i,
    output logic                   locked_o
);

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [lg_inputs_p-1:0] r_ptr;
    logic [lg_inputs_p-1:0] w_ptr_next;
    logic [lg_inputs_p-1:0] r_lock;
    logic [lg_inputs_p-1:0] w_lock_next;

    logic [inputs_p-1:0]    w_ge_ptr;
    logic [inputs_p-1:0]    w_hi_reqs;
    logic [lg_inputs_p-1:0] w_hi_idx;
    logic [lg_inputs_p-1:0] w_any_idx;
    logic                   w_hi_found;
    logic [lg_inputs_p-1:0] w_arb_sel;
    logic [lg_inputs_p-1:0] w_sel;
    logic                   w_v;
    logic                   w_last;
    logic                   w_accept;

    // Requests at or above the pointer win first; otherwise wrap to the lowest valid one.
    generate
        for (genvar gi = 0; gi < inputs_p; gi++) begin : g_mask
            assign w_ge_ptr[gi] = (32'(gi) >= 32'(r_ptr));
        end
    endgenerate

    assign w_hi_reqs = reqs_v_i & w_ge_ptr;

    always_comb begin
        w_hi_idx   = '0;
        w_hi_found = 1'b0;
        w_any_idx  = '0;
        for (int j = inputs_p - 1; j >= 0; j--) begin
            if (w_hi_reqs[j]) begin
                w_hi_idx   = lg_inputs_p'(j);
                w_hi_found = 1'b1;
            end
            if (reqs_v_i[j]) begin
                w_any_idx = lg_inputs_p'(j);
            end
        end
        w_arb_sel = w_hi_found ? w_hi_idx : w_any_idx;
    end

    assign w_sel    = (r_state == ST_LOCKED) ? r_lock : w_arb_sel;
    assign w_v      = (r_state == ST_LOCKED) ? reqs_v_i[r_lock] : (|reqs_v_i);
    assign w_last   = w_v & reqs_last_i[w_sel];

    // Every output is forced quiet while reset is asserted.
    assign v_o      = reset_n_i & w_v;
    assign tag_o    = reset_n_i ? w_sel : '0;
    assign last_o   = reset_n_i & w_last;
    assign locked_o = reset_n_i & (r_state == ST_LOCKED);
    assign w_accept = v_o & ready_i;

    generate
        for (genvar gi = 0; gi < inputs_p; gi++) begin : g_yumi
            assign reqs_yumi_o[gi] = w_accept & (32'(w_sel) == gi);
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_lock_next  = r_lock;
        if (w_accept) begin
            if (w_last) begin
                w_state_next = ST_ARB;
                w_ptr_next   = (w_sel == lg_inputs_p'(inputs_p - 1))
                             ? '0 : w_sel + lg_inputs_p'(1);
            end else begin
                w_state_next = ST_LOCKED;
                w_lock_next  = w_sel;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= ST_ARB;
            r_ptr   <= '0;
            r_lock  <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_lock  <= w_lock_next;
        end
    end

endmodule
